// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART (uart_periph, uart_rx_fsm).
package uart_pkg;

   localparam logic [7:0] UART_TXD = 8'h18;
   localparam logic [7:0] UART_RXD = 8'h1C;
   localparam logic [7:0] UART_CON = 8'h20;

   localparam int CON_RX_VALID  = 0;
   localparam int CON_TX_BUSY   = 1;
   localparam int CON_OVERRUN   = 2;
   localparam int CON_TX_DONE   = 3;
   localparam int CON_FRAME_ERR = 4;
   localparam int CON_LOOPBACK  = 5;

   localparam int OVERSAMPLE = 16;
   localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] OS_HALF = 4'(OVERSAMPLE / 2 - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchroniser plus 16x oversampled 8N1 frame FSM.
// Emits one-cycle rx_done (good stop bit) or rx_ferr (bad stop bit) strobes.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_ferr
);

   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [1:0]           sync_q;
   logic                 rx_s;
   uart_state_e          state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;

   assign rx_s    = sync_q[1];
   assign rx_data = shift_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx_in};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rx_done = 1'b0;
      rx_ferr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick && !rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               cnt_d = cnt_q + 4'd1;
               // Mid-start-bit re-check: a high line here was only a glitch.
               if (cnt_q == OS_HALF) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  state_d = rx_s ? ST_IDLE : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == OS_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BW'(DATA_BITS - 1)) state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == OS_LAST) begin
                  state_d = ST_IDLE;
                  rx_done = rx_s;
                  rx_ferr = !rx_s;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART target: TXD/RXD/CON registers, tick generator and TX FSM.
// Optional macro UART_LOOPBACK_EN adds CON[5] loopback (RX fed from uart_tx).
module uart_periph
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = 651,
   parameter int DATA_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        um_rd,
   input  logic        um_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        uart_rx,
   output logic        uart_tx
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic                 txd_wr, rd_rxd, rd_con, tx_accept;
   logic [CW-1:0]        div_q;
   logic                 tick;
   uart_state_e          tx_state_q, tx_state_d;
   logic [3:0]           tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 tx_line_d, tx_done_set;
   logic [DATA_BITS-1:0] txd_q, rx_byte_q, rx_data;
   logic                 rx_valid_q, overrun_q, tx_done_q, frame_err_q;
   logic                 rx_done, rx_ferr, rx_src, loopback_q;
   logic [5:0]           con_val;
   logic                 unused_bits;

   assign txd_wr    = um_wr && (addr[7:0] == UART_TXD);
   assign rd_rxd    = um_rd && (addr[7:0] == UART_RXD);
   assign rd_con    = um_rd && (addr[7:0] == UART_CON);
   assign tx_accept = txd_wr && !tx_busy_q;
   assign tick      = (div_q == CW'(BAUD_DIV - 1));
   assign unused_bits = ^{addr[31:8], wdata[31:8]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_busy_q  <= 1'b0;
         uart_tx    <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_busy_q  <= tx_busy_d;
         uart_tx    <= tx_line_d;
      end
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      tx_busy_d   = tx_busy_q;
      tx_done_set = 1'b0;
      case (tx_state_q)
         ST_IDLE: begin
            if (tx_accept) begin
               tx_busy_d  = 1'b1;
               tx_shift_d = wdata[DATA_BITS-1:0];
            end else if (tx_busy_q && tick) begin
               tx_state_d = ST_START;
               tx_cnt_d   = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == OS_LAST) begin
                  tx_state_d = ST_DATA;
                  tx_bit_d   = '0;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == OS_LAST) begin
                  tx_bit_d = tx_bit_q + 1'b1;
                  if (tx_bit_q == BW'(DATA_BITS - 1)) tx_state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == OS_LAST) begin
                  tx_state_d  = ST_IDLE;
                  tx_busy_d   = 1'b0;
                  tx_done_set = 1'b1;
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
      // The pin is registered from the next state so it changes on the same edge as the FSM.
      case (tx_state_d)
         ST_START: tx_line_d = 1'b0;
         ST_DATA:  tx_line_d = tx_shift_d[tx_bit_d];
         default:  tx_line_d = 1'b1;
      endcase
   end

`ifdef UART_LOOPBACK_EN
   logic con_wr;
   assign con_wr = um_wr && (addr[7:0] == UART_CON);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       loopback_q <= 1'b0;
      else if (con_wr) loopback_q <= wdata[CON_LOOPBACK];
   end
   assign rx_src = loopback_q ? uart_tx : uart_rx;
`else
   assign loopback_q = 1'b0;
   assign rx_src     = uart_rx;
`endif

   uart_rx_fsm #(
      .DATA_BITS (DATA_BITS)
   ) u_rx (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .rx_in   (rx_src),
      .rx_data (rx_data),
      .rx_done (rx_done),
      .rx_ferr (rx_ferr)
   );

   // Hardware set events take priority over read-side clears on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txd_q       <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (tx_accept) txd_q <= wdata[DATA_BITS-1:0];

         if (rx_done) begin
            rx_byte_q  <= rx_data;
            rx_valid_q <= 1'b1;
         end else if (rd_rxd) begin
            rx_valid_q <= 1'b0;
         end

         if (rx_done && rx_valid_q) overrun_q <= 1'b1;
         else if (rd_con)           overrun_q <= 1'b0;

         if (tx_done_set) tx_done_q <= 1'b1;
         else if (rd_con) tx_done_q <= 1'b0;

         if (rx_ferr)     frame_err_q <= 1'b1;
         else if (rd_con) frame_err_q <= 1'b0;
      end
   end

   always_comb begin
      con_val                = '0;
      con_val[CON_RX_VALID]  = rx_valid_q;
      con_val[CON_TX_BUSY]   = tx_busy_q;
      con_val[CON_OVERRUN]   = overrun_q;
      con_val[CON_TX_DONE]   = tx_done_q;
      con_val[CON_FRAME_ERR] = frame_err_q;
      con_val[CON_LOOPBACK]  = loopback_q;
   end

   always_comb begin
      rdata = '0;
      if (um_rd) begin
         case (addr[7:0])
            UART_TXD: rdata = {{(32-DATA_BITS){1'b0}}, txd_q};
            UART_RXD: rdata = {{(32-DATA_BITS){1'b0}}, rx_byte_q};
            UART_CON: rdata = {26'b0, con_val};
            default:  rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph (BAUD_DIV=4, 64 clk per bit); loopback part under UART_LOOPBACK_EN.
module tb_uart_periph;

   localparam int BIT_CLK = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        um_rd = 1'b0;
   logic        um_wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t       rd_q[$];
   logic [7:0] tx_q[$];

   uart_periph #(.BAUD_DIV(4), .DATA_BITS(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .um_rd   (um_rd),
      .um_wr   (um_wr),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_read(input string name, input logic [7:0] a, input logic [31:0] exp);
      rd_q.push_back('{name: name, val: exp});
      @(posedge clk); #1;
      um_rd = 1'b1;
      addr  = {24'h400000, a};
      @(posedge clk); #1;
      um_rd = 1'b0;
      addr  = '0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      um_wr = 1'b1;
      addr  = {24'h400000, a};
      wdata = d;
      @(posedge clk); #1;
      um_wr = 1'b0;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      @(posedge clk); #1;
      uart_rx = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         wait_clk(BIT_CLK);
      end
      uart_rx = stop_bit;
      wait_clk(BIT_CLK);
      uart_rx = 1'b1;
   endtask

   // Read monitor: every cycle with um_rd high consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (um_rd) begin
            if (rd_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read: got 0x%08h with no expected entry", rdata);
            end else begin
               e = rd_q.pop_front();
               check(e.name, rdata, e.val);
            end
         end
      end
   end

   // Serial monitor: armed only while a frame is expected, samples each bit at its centre.
   initial begin
      logic [7:0] got;
      logic [7:0] exp_b;
      forever begin
         wait (tx_q.size() > 0);
         @(negedge uart_tx);
         wait_clk(BIT_CLK / 2);
         check("tx_start_bit", 32'(uart_tx), 32'd0);
         for (int i = 0; i < 8; i++) begin
            wait_clk(BIT_CLK);
            got[i] = uart_tx;
         end
         wait_clk(BIT_CLK);
         check("tx_stop_bit", 32'(uart_tx), 32'd1);
         exp_b = tx_q.pop_front();
         check("tx_frame_byte", 32'(got), 32'(exp_b));
      end
   end

   initial begin
      #2_000_000;
      total++;
      bad++;
      $display("FAIL watchdog: timeout with %0d reads and %0d frames pending", rd_q.size(), tx_q.size());
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      wait_clk(3);
      check("reset_uart_tx", 32'(uart_tx), 32'd1);
      check("reset_rdata_idle", rdata, 32'h0);
      reset = 1'b0;
      wait_clk(4);

      // Reset in the middle of a frame (data bit 3 of 0xA5 is 0)
      bus_write(8'h18, 32'hA5);
      wait_clk(298);
      check("mid_frame_tx_low", 32'(uart_tx), 32'd0);
      reset = 1'b1;
      #1;
      check("reset_mid_frame_tx", 32'(uart_tx), 32'd1);
      wait_clk(2);
      reset = 1'b0;
      bus_read("con_after_reset", 8'h20, 32'h00);
      bus_read("txd_after_reset", 8'h18, 32'h00);

      // Basic transmit of 0x55
      tx_q.push_back(8'h55);
      bus_write(8'h18, 32'h0000_0055);
      wait_clk(300);
      addr = 32'h4000_0020;
      #1;
      check("rdata_zero_without_rd", rdata, 32'h0);
      addr = '0;
      bus_read("con_busy", 8'h20, 32'h02);
      bus_read("txd_readback", 8'h18, 32'h55);
      wait_clk(400);
      bus_read("con_tx_done", 8'h20, 32'h08);
      bus_read("con_cleared", 8'h20, 32'h00);

      // Write while busy is dropped
      tx_q.push_back(8'h55);
      bus_write(8'h18, 32'h55);
      wait_clk(100);
      bus_write(8'h18, 32'h33);
      wait_clk(100);
      bus_read("txd_not_overwritten", 8'h18, 32'h55);
      bus_read("con_busy_2", 8'h20, 32'h02);
      wait_clk(500);
      bus_read("con_tx_done_2", 8'h20, 32'h08);

      // Single receive
      rx_send(8'hC3, 1'b1);
      wait_clk(10);
      bus_read("con_rx_valid", 8'h20, 32'h01);
      bus_read("rxd_c3", 8'h1C, 32'h0000_00C3);
      bus_read("con_rx_consumed", 8'h20, 32'h00);

      // Overrun, glitch and framing error
      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b1);
      wait_clk(10);
      bus_read("con_overrun", 8'h20, 32'h05);
      bus_read("rxd_22", 8'h1C, 32'h22);
      bus_read("con_after_overrun", 8'h20, 32'h00);
      @(posedge clk); #1;
      uart_rx = 1'b0;
      wait_clk(20);
      uart_rx = 1'b1;
      wait_clk(100);
      bus_read("con_after_glitch", 8'h20, 32'h00);
      rx_send(8'h5A, 1'b0);
      wait_clk(100);
      bus_read("con_frame_err", 8'h20, 32'h10);
      bus_read("rxd_kept_22", 8'h1C, 32'h22);
      bus_read("con_ferr_cleared", 8'h20, 32'h00);

`ifdef UART_LOOPBACK_EN
      bus_write(8'h20, 32'h20);
      bus_read("con_loopback_set", 8'h20, 32'h20);
      tx_q.push_back(8'h7E);
      bus_write(8'h18, 32'h7E);
      wait_clk(720);
      bus_read("con_loopback_rx", 8'h20, 32'h29);
      bus_read("rxd_loopback", 8'h1C, 32'h7E);
      bus_read("con_loopback_after", 8'h20, 32'h20);
`else
      bus_write(8'h20, 32'h20);
      bus_read("con_write_ignored", 8'h20, 32'h00);
`endif

      wait_clk(50);
      check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
